// File: rtl/rst_sync_seq.sv
// Reset synchroniser that releases NUM_CH active-low resets one at a time after a minimum hold.
// Define RST_SEQ_EVT_CNT_EN to add the saturating EVT_CNT count of accepted software resets.
module rst_sync_seq #(
    parameter int NUM_STAGE   = 2,
    parameter int NUM_CH      = 3,
    parameter int MIN_HOLD    = 4,
    parameter int RELEASE_GAP = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SW_RST,
    output logic [NUM_CH-1:0] SYNC_RST,
`ifdef RST_SEQ_EVT_CNT_EN
    output logic [7:0]        EVT_CNT,
`endif
    output logic              RST_DONE
);
    localparam int HOLD_W = $clog2(MIN_HOLD + 1);
    localparam int GAP_W  = $clog2(RELEASE_GAP + 1);
    localparam int CH_W   = $clog2(NUM_CH + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RELEASE_GAP - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] CH_ONE    = NUM_CH'(1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_DONE
    } state_t;

    logic [NUM_STAGE-1:0] r_sync;
    logic                 w_sync_n;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic [HOLD_W-1:0]    w_hold_cnt_nxt;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic [GAP_W-1:0]     w_gap_cnt_nxt;
    logic [CH_W-1:0]      r_ch_cnt;
    logic [CH_W-1:0]      w_ch_cnt_nxt;
    logic [NUM_CH-1:0]    r_sync_rst;
    logic [NUM_CH-1:0]    w_sync_rst_nxt;
    logic                 r_rst_done;
    logic                 w_rst_done_nxt;

    // Deassertion synchroniser; a software reset never touches it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[NUM_STAGE-2:0], 1'b1};
        end
    end

    assign w_sync_n = r_sync[NUM_STAGE-1];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
            r_ch_cnt   <= '0;
            r_sync_rst <= '0;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_ch_cnt   <= w_ch_cnt_nxt;
            r_sync_rst <= w_sync_rst_nxt;
            r_rst_done <= w_rst_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_ch_cnt_nxt   = r_ch_cnt;
        w_sync_rst_nxt = r_sync_rst;
        w_rst_done_nxt = r_rst_done;
        case (r_state)
            ST_HOLD: begin
                // A request while holding only restarts the hold window.
                if (SW_RST) begin
                    w_hold_cnt_nxt = '0;
                end else if (w_sync_n) begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_hold_cnt_nxt = '0;
                        w_gap_cnt_nxt  = '0;
                        w_ch_cnt_nxt   = CH_W'(1);
                        w_sync_rst_nxt = CH_ONE;
                        if (NUM_CH == 1) begin
                            w_rst_done_nxt = 1'b1;
                            w_state_nxt    = ST_DONE;
                        end else begin
                            w_state_nxt    = ST_RELEASE;
                        end
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                    end
                end
            end
            ST_RELEASE, ST_DONE: begin
                if (SW_RST) begin
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = '0;
                    w_gap_cnt_nxt  = '0;
                    w_ch_cnt_nxt   = '0;
                    w_sync_rst_nxt = '0;
                    w_rst_done_nxt = 1'b0;
                end else if (r_state == ST_RELEASE) begin
                    if (r_gap_cnt == GAP_LAST) begin
                        w_gap_cnt_nxt  = '0;
                        w_ch_cnt_nxt   = r_ch_cnt + CH_W'(1);
                        w_sync_rst_nxt = (r_sync_rst << 1) | CH_ONE;
                        if (r_ch_cnt == CH_LAST) begin
                            w_rst_done_nxt = 1'b1;
                            w_state_nxt    = ST_DONE;
                        end
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_HOLD;
            end
        endcase
    end

    assign SYNC_RST = r_sync_rst;
    assign RST_DONE = r_rst_done;

`ifdef RST_SEQ_EVT_CNT_EN
    logic       w_sw_accept;
    logic [7:0] r_evt_cnt;

    assign w_sw_accept = SW_RST && (r_state != ST_HOLD);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_evt_cnt <= '0;
        end else if (w_sw_accept && (r_evt_cnt != 8'hFF)) begin
            r_evt_cnt <= r_evt_cnt + 8'd1;
        end
    end

    assign EVT_CNT = r_evt_cnt;
`endif

endmodule

// File: tb/tb_rst_sync_seq.sv
// Bench for rst_sync_seq: a release-schedule model derived from the restart edge E,
// checked every cycle, plus hand-computed literal values keyed by edge number.
module tb_rst_sync_seq;
    localparam int NS = 2;
    localparam int NC = 3;
    localparam int MH = 4;
    localparam int RG = 2;

    logic          CLK    = 1'b0;
    logic          RST    = 1'b1;
    logic          SW_RST = 1'b0;
    logic [NC-1:0] SYNC_RST;
    logic          RST_DONE;
`ifdef RST_SEQ_EVT_CNT_EN
    logic [7:0]    EVT_CNT;
`endif

    int errors = 0;
    int checks = 0;

    // cyc counts rising edges seen with RST high; m_e is the edge acting as E.
    int cyc     = 0;
    int m_edges = 0;
    bit m_e_ok  = 1'b0;
    int m_e     = 0;
    int m_evt   = 0;

    int lit_sync [int];
    int lit_done [int];
    int lit_evt  [int];

    rst_sync_seq #(
        .NUM_STAGE   (NS),
        .NUM_CH      (NC),
        .MIN_HOLD    (MH),
        .RELEASE_GAP (RG)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SW_RST   (SW_RST),
        .SYNC_RST (SYNC_RST),
`ifdef RST_SEQ_EVT_CNT_EN
        .EVT_CNT  (EVT_CNT),
`endif
        .RST_DONE (RST_DONE)
    );

    always #5 CLK = ~CLK;

    // Number of channels released after edge k, from the release schedule E+MH+i*RG.
    function automatic int released_at(input int k);
        int d;
        int r;
        if (!m_e_ok) return 0;
        d = k - m_e;
        if (d < MH) return 0;
        r = (d - MH) / RG + 1;
        return (r > NC) ? NC : r;
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_edges <= 0;
            m_e_ok  <= 1'b0;
            m_evt   <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_edges < NS) m_edges <= m_edges + 1;
            if (m_edges + 1 == NS) begin
                m_e_ok <= 1'b1;
                m_e    <= cyc + 1;
            end else if (SW_RST && m_edges >= NS) begin
                m_e <= cyc + 1;
                if (released_at(cyc) > 0) m_evt <= (m_evt < 255) ? m_evt + 1 : 255;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    initial begin : compare
        int rel;
        forever begin
            @(negedge CLK or negedge RST);
            #1;
            rel = released_at(cyc);
            chk("sync_rst", int'(SYNC_RST), (1 << rel) - 1);
            chk("rst_done", int'(RST_DONE), (rel == NC) ? 1 : 0);
`ifdef RST_SEQ_EVT_CNT_EN
            chk("evt_cnt", int'(EVT_CNT), m_evt);
`endif
            if (!RST) begin
                chk("async_sync_clear", int'(SYNC_RST), 0);
                chk("async_done_clear", int'(RST_DONE), 0);
`ifdef RST_SEQ_EVT_CNT_EN
                chk("async_evt_clear", int'(EVT_CNT), 0);
`endif
            end
            if (RST && lit_sync.exists(cyc)) begin
                chk("lit_sync", int'(SYNC_RST), lit_sync[cyc]);
                chk("lit_done", int'(RST_DONE), lit_done[cyc]);
                chk("model_lit_sync", (1 << rel) - 1, lit_sync[cyc]);
            end
            if (RST && lit_evt.exists(cyc)) begin
                chk("model_lit_evt", m_evt, lit_evt[cyc]);
`ifdef RST_SEQ_EVT_CNT_EN
                chk("lit_evt", int'(EVT_CNT), lit_evt[cyc]);
`endif
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic set_lit(input int k, input int s, input int d);
        lit_sync[k] = s;
        lit_done[k] = d;
    endtask

    // One-cycle request; n returns the edge that samples it.
    task automatic sw_pulse(output int n);
        SW_RST = 1'b1;
        n = cyc + 1;
        tick(1);
        SW_RST = 1'b0;
    endtask

    initial begin : stim
        int b, n, m, p, s, q, g, x;
        #1 RST = 1'b0;

        // Power-up: E is edge 2 after RST rises.
        #23 RST = 1'b1;
        b = cyc;
        set_lit(b + 5, 0, 0);
        set_lit(b + 6, 1, 0);
        set_lit(b + 7, 1, 0);
        set_lit(b + 8, 3, 0);
        set_lit(b + 9, 3, 0);
        set_lit(b + 10, 7, 1);
        tick(1);
        tick(12);

        // Request in DONE restarts the sequence from its own edge.
        sw_pulse(n);
        set_lit(n, 0, 0);
        set_lit(n + 3, 0, 0);
        set_lit(n + 4, 1, 0);
        set_lit(n + 5, 1, 0);
        set_lit(n + 6, 3, 0);
        set_lit(n + 8, 7, 1);
        lit_evt[n] = 1;
        tick(10);

        // Request in HOLD two edges before release only extends the hold.
        sw_pulse(m);
        tick(1);
        sw_pulse(p);
        set_lit(p, 0, 0);
        set_lit(p + 3, 0, 0);
        set_lit(p + 4, 1, 0);
        set_lit(p + 6, 3, 0);
        set_lit(p + 8, 7, 1);
        lit_evt[p] = 2;
        tick(10);

        // Held request: the last high sample restarts the count.
        SW_RST = 1'b1;
        s = cyc + 1;
        tick(10);
        SW_RST = 1'b0;
        set_lit(s + 9, 0, 0);
        set_lit(s + 12, 0, 0);
        set_lit(s + 13, 1, 0);
        set_lit(s + 15, 3, 0);
        set_lit(s + 17, 7, 1);
        lit_evt[s + 9] = 3;
        tick(10);

        // Short RST glitch mid-release forces a full re-synchronised restart.
        sw_pulse(q);
        set_lit(q + 4, 1, 0);
        tick(4);
        tick(1);
        RST = 1'b0;
        #3 RST = 1'b1;
        g = cyc;
        set_lit(g + 1, 0, 0);
        set_lit(g + 5, 0, 0);
        set_lit(g + 6, 1, 0);
        set_lit(g + 8, 3, 0);
        set_lit(g + 10, 7, 1);
        lit_evt[g + 1] = 0;
        tick(1);
        tick(11);

`ifdef RST_SEQ_EVT_CNT_EN
        // Saturation of the event counter, then clear by RST.
        x = 0;
        for (int i = 0; i < 260; i++) begin
            sw_pulse(x);
            tick(4);
        end
        lit_evt[x] = 255;
        tick(2);
        RST = 1'b0;
        tick(3);
        RST = 1'b1;
        tick(12);
`endif

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
